data_bus_transmit_gen: RTL and testbench

// - Parametrised successor of the logical-layer lane transmit mux. It drives NUM_LANES lanes of LANE_W bits

---
 rtl/data_bus_transmit_gen.sv | 184 ++++++++++++++++++
 tb/tb_data_bus_transmit_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_transmit_gen.sv
// Multi-lane transmit mux: ordered sets shifted MSB-first per lane, or handshaked transport data.
// Optional os_count output is enabled by defining DBT_OS_COUNT_EN.
module data_bus_transmit_gen #(
   parameter int unsigned NUM_LANES    = 2,
   parameter int unsigned LANE_W       = 8,
   parameter int unsigned LANES_ON_DLY = 10,
   parameter int unsigned SYM_MAX      = 15
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  mode,
   input  logic [64*NUM_LANES-1:0]     os_data,
   input  logic                        os_half,
   input  logic                        os_sym_ins,
   input  logic [LANE_W*NUM_LANES-1:0] td_in,
   input  logic                        td_valid,
   output logic                        td_ready,
   output logic [LANE_W*NUM_LANES-1:0] lane_tx,
   output logic                        lane_valid,
   output logic                        tx_lanes_on,
   output logic                        os_sent,
   output logic [3:0]                  sym_cnt
`ifdef DBT_OS_COUNT_EN
   ,
   output logic [15:0]                 os_count
`endif
);

   localparam int unsigned MaxBeats = 64 / LANE_W;
   localparam int unsigned BeatW    = (MaxBeats > 2) ? $clog2(MaxBeats) : 1;
   localparam int unsigned LaneBits = LANE_W * NUM_LANES;
   localparam int unsigned OsBits   = 64 * NUM_LANES;
   localparam logic [3:0]  SymMax   = 4'(SYM_MAX);
   localparam logic [7:0]  OnDly    = 8'(LANES_ON_DLY);

   typedef enum logic [1:0] {
      StOff  = 2'b00,
      StOs   = 2'b01,
      StData = 2'b10,
      StZero = 2'b11
   } state_e;

   state_e              state_q, state_d;
   logic [BeatW-1:0]    beat_q, beat_d, beat_last;
   logic [OsBits-1:0]   shadow_os_q, live_os, cur_os;
   logic                shadow_half_q, shadow_ins_q;
   logic                cur_half, cur_ins, os_start, os_last;
   logic [3:0]          sym_cnt_q, sym_cnt_d;
   logic [7:0]          on_cnt_q, on_cnt_d;
   logic                on_q, on_d;
   logic [LaneBits-1:0] os_beat, lane_tx_d;
   logic                lane_valid_d, os_sent_d;

   // Symbol insertion is folded into the captured word so the shadow holds exactly what is sent.
   always_comb begin
      live_os = os_data;
      if (os_sym_ins) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            live_os[64*k+36 +: 8] = {sym_cnt_q, ~sym_cnt_q};
         end
      end
   end

   // Beat 0 uses the live inputs directly; later beats come from the shadow captured at beat 0.
   assign os_start = (beat_q == '0);
   assign cur_os   = os_start ? live_os    : shadow_os_q;
   assign cur_half = os_start ? os_half    : shadow_half_q;
   assign cur_ins  = os_start ? os_sym_ins : shadow_ins_q;

   assign beat_last = cur_half ? BeatW'(MaxBeats / 2 - 1) : BeatW'(MaxBeats - 1);
   assign os_last   = (beat_q == beat_last);

   always_comb begin
      os_beat = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         os_beat[LANE_W*k +: LANE_W] =
            LANE_W'(cur_os[64*k +: 64] >> (64 - LANE_W - int'(beat_q) * LANE_W));
      end
   end

   always_comb begin
      state_d = state_e'(mode);
      // An ordered set in flight always completes before the state may change.
      if (state_q == StOs && !os_last) begin
         state_d = StOs;
      end
   end

   always_comb begin
      beat_d    = '0;
      sym_cnt_d = sym_cnt_q;
      if (state_q == StOs) begin
         beat_d = os_last ? '0 : beat_q + 1'b1;
         if (state_d != StOs) begin
            sym_cnt_d = '0;
         end else if (os_last && cur_ins && sym_cnt_q < SymMax) begin
            sym_cnt_d = sym_cnt_q + 4'd1;
         end
      end
   end

   always_comb begin
      lane_tx_d    = '0;
      lane_valid_d = 1'b0;
      os_sent_d    = 1'b0;
      unique case (state_q)
         StOs: begin
            lane_tx_d    = os_beat;
            lane_valid_d = 1'b1;
            os_sent_d    = os_last;
         end
         StData: begin
            if (td_valid) begin
               lane_tx_d    = td_in;
               lane_valid_d = 1'b1;
            end
         end
         StZero: begin
            lane_valid_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      on_cnt_d = '0;
      on_d     = 1'b0;
      if (state_q != StOff) begin
         on_cnt_d = (on_cnt_q == OnDly) ? on_cnt_q : on_cnt_q + 8'd1;
         on_d     = on_q | (on_cnt_d == OnDly);
      end
   end

   assign td_ready = (state_q == StData);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StOff;
         beat_q        <= '0;
         shadow_os_q   <= '0;
         shadow_half_q <= 1'b0;
         shadow_ins_q  <= 1'b0;
         sym_cnt_q     <= '0;
         on_cnt_q      <= '0;
         on_q          <= 1'b0;
         lane_tx       <= '0;
         lane_valid    <= 1'b0;
         os_sent       <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         sym_cnt_q  <= sym_cnt_d;
         on_cnt_q   <= on_cnt_d;
         on_q       <= on_d;
         lane_tx    <= lane_tx_d;
         lane_valid <= lane_valid_d;
         os_sent    <= os_sent_d;
         if (state_q == StOs && os_start) begin
            shadow_os_q   <= live_os;
            shadow_half_q <= os_half;
            shadow_ins_q  <= os_sym_ins;
         end
      end
   end

   assign sym_cnt     = sym_cnt_q;
   assign tx_lanes_on = on_q;

`ifdef DBT_OS_COUNT_EN
   logic [15:0] os_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         os_count_q <= '0;
      end else if (os_sent_d) begin
         os_count_q <= os_count_q + 16'd1;
      end
   end

   assign os_count = os_count_q;
`endif

endmodule

// File: tb/tb_data_bus_transmit_gen.sv
// Directed bench for data_bus_transmit_gen at NUM_LANES=2, LANE_W=8, LANES_ON_DLY=10, SYM_MAX=15.
module tb_data_bus_transmit_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic [127:0] os_data;
   logic        os_half;
   logic        os_sym_ins;
   logic [15:0] td_in;
   logic        td_valid;
   logic        td_ready;
   logic [15:0] lane_tx;
   logic        lane_valid;
   logic        tx_lanes_on;
   logic        os_sent;
   logic [3:0]  sym_cnt;
`ifdef DBT_OS_COUNT_EN
   logic [15:0] os_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] os64_exp [8];
   logic [3:0]  c;
   logic [3:0]  cn;

   always #5 clk = ~clk;

   data_bus_transmit_gen #(
      .NUM_LANES   (2),
      .LANE_W      (8),
      .LANES_ON_DLY(10),
      .SYM_MAX     (15)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .os_data    (os_data),
      .os_half    (os_half),
      .os_sym_ins (os_sym_ins),
      .td_in      (td_in),
      .td_valid   (td_valid),
      .td_ready   (td_ready),
      .lane_tx    (lane_tx),
      .lane_valid (lane_valid),
      .tx_lanes_on(tx_lanes_on),
      .os_sent    (os_sent),
      .sym_cnt    (sym_cnt)
`ifdef DBT_OS_COUNT_EN
      ,
      .os_count   (os_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      os64_exp[0] = 16'hFE01; os64_exp[1] = 16'hDC23;
      os64_exp[2] = 16'hBA45; os64_exp[3] = 16'h9867;
      os64_exp[4] = 16'h7689; os64_exp[5] = 16'h54AB;
      os64_exp[6] = 16'h32CD; os64_exp[7] = 16'h10EF;

      rst        = 1'b1;
      mode       = 2'b00;
      os_data    = {~64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
      os_half    = 1'b0;
      os_sym_ins = 1'b0;
      td_in      = 16'h0000;
      td_valid   = 1'b0;

      // Reset state
      tick();
      chk("rst_lane_tx", lane_tx, 0);
      chk("rst_lane_valid", lane_valid, 0);
      chk("rst_td_ready", td_ready, 0);
      chk("rst_lanes_on", tx_lanes_on, 0);
      chk("rst_os_sent", os_sent, 0);
      chk("rst_sym_cnt", sym_cnt, 0);

      // 32-bit ordered sets with symbol-counter insertion, 20 in a row
      rst        = 1'b0;
      mode       = 2'b01;
      os_half    = 1'b1;
      os_sym_ins = 1'b1;
      tick();
      chk("os_latency_valid", lane_valid, 0);
      for (int n = 0; n < 20; n++) begin
         c  = (n < 15) ? 4'(n) : 4'd15;
         cn = ~c;
         for (int b = 0; b < 4; b++) begin
            tick();
            case (b)
               0: chk("os32_beat0", lane_tx, 16'hFE01);
               1: chk("os32_beat1", lane_tx, 16'hDC23);
               2: chk("os32_beat2", lane_tx, {4'hB, c, 4'h4, c});
               default: chk("os32_beat3", lane_tx, {cn, 4'h8, cn, 4'h7});
            endcase
            chk("os32_valid", lane_valid, 1);
            chk("os32_os_sent", os_sent, (b == 3) ? 1 : 0);
         end
         chk("os32_sym_cnt", sym_cnt, (n < 14) ? n + 1 : 15);
      end
      chk("os32_td_ready", td_ready, 0);

      // 64-bit ordered set, no insertion; sym_cnt holds
      os_half    = 1'b0;
      os_sym_ins = 1'b0;
      for (int b = 0; b < 8; b++) begin
         tick();
         chk("os64_beat", lane_tx, os64_exp[b]);
         chk("os64_os_sent", os_sent, (b == 7) ? 1 : 0);
      end
      chk("os64_sym_hold", sym_cnt, 15);

      // Back-to-back repeat, then mode change at beat 3
      for (int b = 0; b < 4; b++) begin
         tick();
         chk("rep_beat", lane_tx, os64_exp[b]);
      end
      mode  = 2'b10;
      td_in = 16'hA55A;
      for (int b = 4; b < 7; b++) begin
         tick();
         chk("chg_beat", lane_tx, os64_exp[b]);
         chk("chg_td_ready", td_ready, 0);
         chk("chg_os_sent", os_sent, 0);
      end
      tick();
      chk("chg_last_beat", lane_tx, 16'h10EF);
      chk("chg_last_sent", os_sent, 1);
      chk("chg_td_ready_on", td_ready, 1);
      chk("chg_sym_clear", sym_cnt, 0);

      // Data handshake, valid 1,0,1
      td_valid = 1'b1;
      tick();
      chk("data1_tx", lane_tx, 16'hA55A);
      chk("data1_valid", lane_valid, 1);
      td_valid = 1'b0;
      tick();
      chk("data2_tx", lane_tx, 16'h0000);
      chk("data2_valid", lane_valid, 0);
      td_valid = 1'b1;
      tick();
      chk("data3_tx", lane_tx, 16'hA55A);
      chk("data3_valid", lane_valid, 1);
      chk("data_lanes_on", tx_lanes_on, 1);

      // Go OFF: lanes_on drops one edge after entering OFF
      td_valid = 1'b0;
      mode     = 2'b00;
      tick();
      chk("off_enter_lanes_on", tx_lanes_on, 1);
      tick();
      chk("off_lanes_on", tx_lanes_on, 0);
      chk("off_valid", lane_valid, 0);
      chk("off_td_ready", td_ready, 0);

      // ZERO from OFF: lanes_on after exactly 10 cycles in ZERO
      mode = 2'b11;
      tick();
      chk("zero_latency_valid", lane_valid, 0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("zero_lanes_on", tx_lanes_on, (i == 10) ? 1 : 0);
         if (i == 1) begin
            chk("zero_valid", lane_valid, 1);
            chk("zero_tx", lane_tx, 0);
         end
      end

      // Reset in the middle of an ordered set
      mode = 2'b01;
      tick();
      for (int b = 0; b < 5; b++) begin
         tick();
         chk("pre_rst_beat", lane_tx, os64_exp[b]);
      end
      rst = 1'b1;
      tick();
      chk("midrst_tx", lane_tx, 0);
      chk("midrst_valid", lane_valid, 0);
      chk("midrst_os_sent", os_sent, 0);
      chk("midrst_sym", sym_cnt, 0);
      chk("midrst_lanes_on", tx_lanes_on, 0);
      chk("midrst_td_ready", td_ready, 0);
`ifdef DBT_OS_COUNT_EN
      chk("midrst_os_count", os_count, 0);
`endif
      rst = 1'b0;
      tick();
      tick();
      chk("restart_beat0", lane_tx, 16'hFE01);
      chk("restart_valid", lane_valid, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
